// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage divider: FSM state encoding and
// handshake constants.
package ex_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_DIV_ZERO = 2'b01,
        S_ON       = 2'b10,
        S_END      = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/ex_div.sv
// Multi-cycle restoring divider for the EX stage: one quotient bit per cycle.
// Define EX_DIV_SIGNED_EN to honour signed_div; otherwise every divide is unsigned.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_div,
    input  logic [DATA_W-1:0]     opdata1,
    input  logic [DATA_W-1:0]     opdata2,
    input  logic                  annul,
    output logic [2*DATA_W-1:0]   result,
    output logic                  ready,
    output logic                  stallreq
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    div_state_e            r_state;
    div_state_e            w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_rem;
    logic [DATA_W-1:0]     r_quo;
    logic [DATA_W-1:0]     r_divisor;
    logic [2*DATA_W-1:0]   r_result;

    logic                  w_accept;
    logic                  w_last;
    logic [DATA_W-1:0]     w_mag_a;
    logic [DATA_W-1:0]     w_mag_b;
    logic [DATA_W:0]       w_partial;
    logic [DATA_W:0]       w_diff;
    logic                  w_qbit;
    logic [DATA_W-1:0]     w_rem_next;
    logic [DATA_W-1:0]     w_quo_next;
    logic [DATA_W-1:0]     w_rem_fix;
    logic [DATA_W-1:0]     w_quo_fix;

    assign w_accept = (r_state == S_IDLE) && (start == DIV_START) && !annul;
    assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));

`ifdef EX_DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_a_neg;
    logic w_b_neg;

    assign w_a_neg = signed_div & opdata1[DATA_W-1];
    assign w_b_neg = signed_div & opdata2[DATA_W-1];
    assign w_mag_a = w_a_neg ? -opdata1 : opdata1;
    assign w_mag_b = w_b_neg ? -opdata2 : opdata2;

    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end
    end

    assign w_quo_fix = r_neg_q ? -w_quo_next : w_quo_next;
    assign w_rem_fix = r_neg_r ? -w_rem_next : w_rem_next;
`else
    logic w_unused_signed;

    assign w_unused_signed = signed_div;
    assign w_mag_a         = opdata1;
    assign w_mag_b         = opdata2;
    assign w_quo_fix       = w_quo_next;
    assign w_rem_fix       = w_rem_next;
`endif

    // One extra bit on the partial remainder keeps the trial subtract's borrow visible.
    assign w_partial  = {r_rem, r_quo[DATA_W-1]};
    assign w_diff     = w_partial - {1'b0, r_divisor};
    assign w_qbit     = ~w_diff[DATA_W];
    assign w_rem_next = w_qbit ? w_diff[DATA_W-1:0] : w_partial[DATA_W-1:0];
    assign w_quo_next = {r_quo[DATA_W-2:0], w_qbit};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets a default before the case so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (opdata2 == '0) ? S_DIV_ZERO : S_ON;
                end
            end
            S_DIV_ZERO: w_next = annul ? S_IDLE : S_END;
            S_ON: begin
                if (annul) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_END;
                end
            end
            S_END:   w_next = (start == DIV_START) ? S_END : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready    = DIV_RESULT_NOT_READY;
        result   = '0;
        if (r_state == S_END) begin
            ready  = DIV_RESULT_READY;
            result = r_result;
        end
        stallreq = start & ~ready;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        r_quo     <= w_mag_a;
                        r_divisor <= w_mag_b;
                        r_result  <= '0;
                    end
                end
                S_DIV_ZERO: r_result <= '0;
                S_ON: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    if (w_last && !annul) begin
                        r_result <= {w_rem_fix, w_quo_fix};
                    end
                end
                S_END: begin
                    if (start == DIV_STOP) begin
                        r_result <= '0;
                    end
                end
                default: r_result <= '0;
            endcase
        end
    end

endmodule
